axi_10g_ethernet_0_pkt_fifo_ctrl: RTL and testbench

// Single-clock store-and-forward packet FIFO controller driving the 68-bit dual-port block RAM
// (2-cycle registered write path, 1-cycle registered read). Accepts 64-bit AXI-Stream frames

---
 rtl/axi_10g_ethernet_0_fifo_pkg.sv | 30 +++
 rtl/axi_10g_ethernet_0_fifo_out_skid.sv | 41 ++++
 rtl/axi_10g_ethernet_0_pkt_fifo_ctrl.sv | 172 +++++++++++++++++
 tb/tb_axi_10g_ethernet_0_pkt_fifo_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_10g_ethernet_0_fifo_pkg.sv
// Shared definitions for the 10G packet FIFO: RAM word layout, tkeep packing helpers,
// and the write-side FSM encoding.
package axi_10g_ethernet_0_fifo_pkg;

  localparam int WORD_W   = 68;
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 63;
  localparam int KEEP_LSB = 64;
  localparam int KEEP_MSB = 66;
  localparam int LAST_BIT = 67;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_FRAME = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

  // Index of the highest set byte enable; tkeep is contiguous from bit 0.
  function automatic logic [2:0] keep_enc(input logic [7:0] keep);
    keep_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (keep[i]) keep_enc = 3'(i);
    end
  endfunction

  function automatic logic [7:0] keep_dec(input logic [2:0] enc);
    keep_dec = 8'((9'd2 << enc) - 9'd1);
  endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_fifo_out_skid.sv
// Two-entry output skid buffer between the RAM read port and m_axis; head word stays
// put until popped so the AXI stream is stable under back-pressure.
module axi_10g_ethernet_0_fifo_out_skid
  import axi_10g_ethernet_0_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              sreset,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  output logic [1:0]        o_count
);

  logic [WORD_W-1:0] r_word [2];
  logic              r_wr_idx;
  logic              r_rd_idx;
  logic [1:0]        r_count;

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_idx <= ~r_wr_idx;
      if (i_pop)  r_rd_idx <= ~r_rd_idx;
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_word[r_wr_idx] <= i_data;
  end

  assign o_data  = r_word[r_rd_idx];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/axi_10g_ethernet_0_pkt_fifo_ctrl.sv
// Store-and-forward packet FIFO controller for the 10G MAC RX path: writes beats into an
// external 68-bit RAM, commits good frames, rewinds bad/overflowing ones, replays on m_axis.
module axi_10g_ethernet_0_pkt_fifo_ctrl
  import axi_10g_ethernet_0_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  sreset,
  input  logic [63:0]           s_axis_tdata,
  input  logic [7:0]            s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [WORD_W-1:0]     ram_data_in,
  output logic                  ram_wr_allow,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_allow,
  input  logic [WORD_W-1:0]     ram_data_out,
  output logic [ADDR_WIDTH-1:0] frames_stored,
  output logic [15:0]           drop_count
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  wr_state_t             r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_nxt, w_wr_ptr_inc;
  logic [ADDR_WIDTH-1:0] r_wr_start, w_wr_start_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_start_d1, r_wr_start_vis;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_frames;
  logic [15:0]           r_drops;
  logic                  r_ram_wr_allow;
  logic [ADDR_WIDTH-1:0] r_ram_wr_addr;
  logic [WORD_W-1:0]     r_ram_wr_data;
  logic                  r_rd_pend;

  logic              w_beat, w_full, w_do_write, w_commit, w_drop;
  logic              w_rd_issue, w_pop, w_last_pop;
  logic [WORD_W-1:0] w_head;
  logic              w_head_vld;
  logic [1:0]        w_skid_cnt;
  logic [2:0]        w_occ_next;

  assign s_axis_tready = !sreset;
  assign w_beat        = s_axis_tvalid & s_axis_tready;
  assign w_wr_ptr_inc  = r_wr_ptr + 1'b1;
  // One word is always kept free so full and empty stay distinguishable.
  assign w_full        = (w_wr_ptr_inc == r_rd_ptr);

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_wr_start_nxt = r_wr_start;
    w_do_write     = 1'b0;
    w_commit       = 1'b0;
    w_drop         = 1'b0;
    if (w_beat) begin
      case (r_state)
        WR_IDLE, WR_FRAME: begin
          if (w_full) begin
            w_wr_ptr_nxt = r_wr_start;
            if (s_axis_tlast) begin
              w_drop      = 1'b1;
              w_state_nxt = WR_IDLE;
            end else begin
              w_state_nxt = WR_DROP;
            end
          end else begin
            w_do_write   = 1'b1;
            w_wr_ptr_nxt = w_wr_ptr_inc;
            if (s_axis_tlast) begin
              w_state_nxt = WR_IDLE;
              if (s_axis_tuser) begin
                w_wr_ptr_nxt = r_wr_start;
                w_drop       = 1'b1;
              end else begin
                w_wr_start_nxt = w_wr_ptr_inc;
                w_commit       = 1'b1;
              end
            end else begin
              w_state_nxt = WR_FRAME;
            end
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            w_drop      = 1'b1;
            w_state_nxt = WR_IDLE;
          end
        end
        default: w_state_nxt = WR_IDLE;
      endcase
    end
  end

  // Read issue: occupancy counts the word returning next cycle and the pop happening now,
  // which lets a single-cycle RAM read sustain one beat per cycle.
  assign w_pop      = w_head_vld & m_axis_tready;
  assign w_last_pop = w_pop & w_head[LAST_BIT];
  assign w_occ_next = 3'(w_skid_cnt) + 3'(r_rd_pend) - 3'(w_pop);
  assign w_rd_issue = !sreset && (r_rd_ptr != r_wr_start_vis) && (w_occ_next < 3'd2);

  // Stage p0 -> p1: beat accepted, RAM write request and pointer updates registered.
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state        <= WR_IDLE;
      r_wr_ptr       <= '0;
      r_wr_start     <= '0;
      r_wr_start_d1  <= '0;
      r_wr_start_vis <= '0;
      r_rd_ptr       <= '0;
      r_rd_pend      <= 1'b0;
      r_ram_wr_allow <= 1'b0;
      r_ram_wr_addr  <= '0;
      r_frames       <= '0;
      r_drops        <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_wr_start <= w_wr_start_nxt;
      // Commit reaches the read side only after the RAM's own two-stage write pipe.
      r_wr_start_d1  <= r_wr_start;
      r_wr_start_vis <= r_wr_start_d1;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rd_pend      <= w_rd_issue;
      r_ram_wr_allow <= w_do_write;
      if (w_do_write) r_ram_wr_addr <= r_wr_ptr;
      if (w_drop) r_drops <= sat_inc16(r_drops);
      if (w_commit && !w_last_pop)      r_frames <= r_frames + 1'b1;
      else if (!w_commit && w_last_pop) r_frames <= r_frames - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_write) r_ram_wr_data <= {s_axis_tlast, keep_enc(s_axis_tkeep), s_axis_tdata};
  end

  // Stage p2 -> p3: RAM read word lands in the skid buffer that drives m_axis.
  axi_10g_ethernet_0_fifo_out_skid u_skid (
    .clk     (clk),
    .sreset  (sreset),
    .i_push  (r_rd_pend),
    .i_data  (ram_data_out),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_head_vld),
    .o_count (w_skid_cnt)
  );

  assign ram_wr_allow  = r_ram_wr_allow;
  assign ram_wr_addr   = r_ram_wr_addr;
  assign ram_data_in   = r_ram_wr_allow ? r_ram_wr_data : '0;
  assign ram_rd_addr   = r_rd_ptr;
  assign ram_rd_allow  = w_rd_issue;
  assign m_axis_tvalid = w_head_vld;
  assign m_axis_tdata  = w_head_vld ? w_head[DATA_MSB:DATA_LSB] : '0;
  assign m_axis_tkeep  = w_head_vld ? keep_dec(w_head[KEEP_MSB:KEEP_LSB]) : '0;
  assign m_axis_tlast  = w_head_vld & w_head[LAST_BIT];
  assign frames_stored = r_frames;
  assign drop_count    = r_drops;

endmodule

// File: tb/tb_axi_10g_ethernet_0_pkt_fifo_ctrl.sv
// Bench for the 10G packet FIFO controller with a behavioural dual-port RAM alongside;
// a frame-level reference model feeds a scoreboard queue checked by an output monitor.
module tb_axi_10g_ethernet_0_pkt_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic          clk;
  logic          sreset;
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic          s_axis_tready;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [AW-1:0] ram_wr_addr;
  logic [67:0]   ram_data_in;
  logic          ram_wr_allow;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_rd_allow;
  logic [67:0]   ram_data_out;
  logic [AW-1:0] frames_stored;
  logic [15:0]   drop_count;

  axi_10g_ethernet_0_pkt_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .sreset        (sreset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .ram_wr_addr   (ram_wr_addr),
    .ram_data_in   (ram_data_in),
    .ram_wr_allow  (ram_wr_allow),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_allow  (ram_rd_allow),
    .ram_data_out  (ram_data_out),
    .frames_stored (frames_stored),
    .drop_count    (drop_count)
  );

  // Dual-port RAM: write inputs registered once, then written; registered read.
  logic [67:0]   mem [DEPTH];
  logic          we_q;
  logic [AW-1:0] wa_q;
  logic [67:0]   wd_q;

  always_ff @(posedge clk) begin
    we_q <= ram_wr_allow;
    wa_q <= ram_wr_addr;
    wd_q <= ram_data_in;
    if (we_q) mem[wa_q] <= wd_q;
    if (sreset) ram_data_out <= '0;
    else if (ram_rd_allow) ram_data_out <= mem[ram_rd_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_chk = 0;
  int    n_err = 0;
  int    n_popped = 0;
  int    exp_drops = 0;
  int    mode = 1;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // tready pattern: 0 always ready, 1 never ready, 2 alternating, 3 random.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'b0;
        2:       m_axis_tready = !m_axis_tready;
        default: m_axis_tready = (($urandom & 32'd1) != 0);
      endcase
    end
  end

  // Monitor: a beat presented with tready at the falling edge is consumed at the next rise.
  initial begin
    beat_t e, got, held;
    bit    hold_v;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (sreset) begin
        hold_v = 1'b0;
      end else begin
        got = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
        if (hold_v) chk("stall_stable", 80'(got), 80'(held));
        if (m_axis_tvalid && m_axis_tready) begin
          hold_v = 1'b0;
          n_chk++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got data %0h, required no beat", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL beat %0d: got d=%0h k=%0h l=%0b, required d=%0h k=%0h l=%0b",
                       n_popped, got.d, got.k, got.l, e.d, e.k, e.l);
            end
            n_popped++;
          end
        end else if (m_axis_tvalid) begin
          hold_v = 1'b1;
          held   = got;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  // Reference: a frame survives unless marked bad or it cannot fit beside the beats
  // still waiting to leave (one word of the RAM always stays empty).
  task automatic send_frame(input int len, input bit bad, input logic [7:0] last_keep);
    bit          good;
    beat_t       b;
    logic [7:0]  kk;
    good = !bad && (exp_q.size() + len <= DEPTH - 1);
    if (!good) exp_drops++;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.l = (i == len - 1);
      kk  = last_keep;
      if (kk == 8'h00) kk = 8'((9'd1 << $urandom_range(8, 1)) - 9'd1);
      b.k = b.l ? kk : 8'hFF;
      if (good) exp_q.push_back(b);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.l;
      s_axis_tuser  = b.l & bad;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d beats still outstanding, required 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int n;
    int len;
    sreset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 80'(m_axis_tvalid), 80'd0);
    chk("rst_s_tready", 80'(s_axis_tready), 80'd0);
    chk("rst_frames", 80'(frames_stored), 80'd0);
    chk("rst_drops", 80'(drop_count), 80'd0);
    chk("rst_wr_allow", 80'(ram_wr_allow), 80'd0);
    chk("rst_rd_allow", 80'(ram_rd_allow), 80'd0);
    sreset = 1'b0;
    mode   = 0;
    @(posedge clk); #1;
    chk("s_tready_run", 80'(s_axis_tready), 80'd1);

    // 3-beat good frame, latency from commit to first output beat.
    send_frame(3, 1'b0, 8'h0F);
    chk("t1_frames_commit", 80'(frames_stored), 80'd1);
    lat = 0;
    while (!m_axis_tvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t1_latency", 80'(lat), 80'd4);
    wait_drain("t1");
    chk("t1_frames_end", 80'(frames_stored), 80'd0);

    // Bad frame followed by a good one.
    send_frame(3, 1'b1, 8'h00);
    send_frame(2, 1'b0, 8'h01);
    wait_drain("t2");
    chk("t2_drops", 80'(drop_count), 80'(exp_drops));

    // Oversized frame with the output stalled.
    mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(20, 1'b0, 8'hFF);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_drops", 80'(drop_count), 80'(exp_drops));
    chk("t3_frames", 80'(frames_stored), 80'd0);
    chk("t3_m_tvalid", 80'(m_axis_tvalid), 80'd0);
    chk("t3_rd_allow", 80'(ram_rd_allow), 80'd0);
    mode = 0;

    // Alternating back-pressure on an 8-beat frame.
    mode = 2;
    send_frame(8, 1'b0, 8'h00);
    wait_drain("t4");
    mode = 0;

    // Ten back-to-back 3-beat frames: pointers wrap the 16-word RAM.
    for (int f = 0; f < 10; f++) send_frame(3, 1'b0, 8'h00);
    wait_drain("t5");
    chk("t5_frames", 80'(frames_stored), 80'd0);
    chk("t5_drops", 80'(drop_count), 80'(exp_drops));

    // Random frames, bad flags, gaps and back-pressure.
    mode = 3;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(8, 1);
      n = 0;
      while (exp_q.size() + len > DEPTH - 1 && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      if (exp_q.size() + len > DEPTH - 1) begin
        n_chk++;
        n_err++;
        $display("FAIL rnd_space: %0d beats outstanding, required <= %0d", exp_q.size(), DEPTH - 1 - len);
      end
      send_frame(len, ($urandom_range(4, 0) == 0), 8'h00);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end
    wait_drain("rnd");
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rnd_frames", 80'(frames_stored), 80'd0);
    chk("rnd_drops", 80'(drop_count), 80'(exp_drops));

    // Reset while the second output beat is on the bus.
    send_frame(6, 1'b0, 8'h00);
    base = n_popped;
    n = 0;
    while (n_popped < base + 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_beat2_valid", 80'(m_axis_tvalid), 80'd1);
    sreset = 1'b1;
    @(posedge clk); #1;
    chk("t6_m_tvalid", 80'(m_axis_tvalid), 80'd0);
    chk("t6_frames", 80'(frames_stored), 80'd0);
    chk("t6_drops", 80'(drop_count), 80'd0);
    chk("t6_rd_addr", 80'(ram_rd_addr), 80'd0);
    chk("t6_wr_addr", 80'(ram_wr_addr), 80'd0);
    exp_q.delete();
    exp_drops = 0;
    sreset = 1'b0;
    @(posedge clk); #1;
    send_frame(4, 1'b0, 8'h00);
    wait_drain("t6_after");
    chk("t6_frames_after", 80'(frames_stored), 80'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
